// File: rtl/page_cam.sv
`default_nettype none
// ============================================================================
//  Module      : page_cam
//  Description : 32-entry page-translation CAM. Each entry holds
//                {valid, key[7:0], data[7:0]} where key = {vpn[3:0], pid[3:0]}.
//                Commands (write / delete / lookup) are accepted in IDLE and
//                resolved by a sequential scan of one entry per clock, then a
//                single RESP cycle before the next command can be taken.
//  Ports       : clk       - single clock, rising edge
//                rst       - asynchronous active-high reset
//                cmd[1:0]  - 00 idle, 01 write, 10 delete, 11 lookup
//                key[7:0]  - search tag {vpn, pid}
//                datain    - physical address stored by a write
//                dataout   - physical address returned by a lookup hit
//                outvalid  - one-cycle pulse on lookup hit
//                pagefault - one-cycle pulse on lookup miss, delete miss, or
//                            write of a new key into a full table
//                outrdy    - high when a new command can be accepted
//                full      - high when all 32 entries are valid
//  Revision    : 1.0 - initial release
// ============================================================================
module page_cam (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cmd,
   input  logic [7:0] key,
   input  logic [7:0] datain,
   output logic [7:0] dataout,
   output logic       outvalid,
   output logic       pagefault,
   output logic       outrdy,
   output logic       full
);

   localparam logic [1:0] c_CMD_IDLE   = 2'b00;
   localparam logic [1:0] c_CMD_WRITE  = 2'b01;
   localparam logic [1:0] c_CMD_DELETE = 2'b10;
   localparam logic [1:0] c_CMD_LOOKUP = 2'b11;
   localparam int         c_ENTRIES    = 32;
   localparam logic [4:0] c_LAST_IDX   = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_t                 r_state;
   logic [1:0]             r_cmd;
   logic [7:0]             r_key;
   logic [7:0]             r_din;
   logic [4:0]             r_idx;
   logic                   r_free_found;
   logic [4:0]             r_free_idx;
   logic [c_ENTRIES-1:0]   r_valid;
   logic [7:0]             r_keys [c_ENTRIES];
   logic [7:0]             r_data [c_ENTRIES];
   logic [7:0]             r_dataout;
   logic                   r_outvalid;
   logic                   r_pagefault;
   logic                   r_outrdy;

   // ---------------------------------------------------------------------
   // Next-state wires
   // ---------------------------------------------------------------------
   state_t                 w_state_nxt;
   logic [1:0]             w_cmd_nxt;
   logic [7:0]             w_key_nxt;
   logic [7:0]             w_din_nxt;
   logic [4:0]             w_idx_nxt;
   logic                   w_free_found_nxt;
   logic [4:0]             w_free_idx_nxt;
   logic [7:0]             w_dataout_nxt;
   logic                   w_outvalid_nxt;
   logic                   w_pagefault_nxt;
   logic                   w_outrdy_nxt;
   logic                   w_tbl_we;
   logic [4:0]             w_tbl_idx;
   logic                   w_set_valid;
   logic                   w_clr_valid;

   logic                   w_match;
   logic                   w_last;
   logic                   w_free_here;
   logic                   w_free_any;
   logic [4:0]             w_free_sel;

   // Entry under comparison this cycle is r_idx (entry i-1 at edge Ei).
   assign w_match     = r_valid[r_idx] && (r_keys[r_idx] == r_key);
   assign w_last      = (r_idx == c_LAST_IDX);
   assign w_free_here = !r_valid[r_idx];
   // The entry compared on the final edge must also count as a free
   // candidate, so fold it in combinationally rather than waiting a cycle.
   assign w_free_any  = r_free_found || w_free_here;
   assign w_free_sel  = r_free_found ? r_free_idx : r_idx;

   assign full      = &r_valid;
   assign dataout   = r_dataout;
   assign outvalid  = r_outvalid;
   assign pagefault = r_pagefault;
   assign outrdy    = r_outrdy;

   // ---------------------------------------------------------------------
   // Next-state / output decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_cmd_nxt        = r_cmd;
      w_key_nxt        = r_key;
      w_din_nxt        = r_din;
      w_idx_nxt        = r_idx;
      w_free_found_nxt = r_free_found;
      w_free_idx_nxt   = r_free_idx;
      w_dataout_nxt    = r_dataout;
      w_outvalid_nxt   = r_outvalid;
      w_pagefault_nxt  = r_pagefault;
      w_outrdy_nxt     = r_outrdy;
      w_tbl_we         = 1'b0;
      w_tbl_idx        = r_idx;
      w_set_valid      = 1'b0;
      w_clr_valid      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_outvalid_nxt  = 1'b0;
            w_pagefault_nxt = 1'b0;
            w_outrdy_nxt    = 1'b1;
            if (cmd != c_CMD_IDLE) begin
               w_cmd_nxt        = cmd;
               w_key_nxt        = key;
               w_din_nxt        = datain;
               w_idx_nxt        = 5'd0;
               w_free_found_nxt = 1'b0;
               w_free_idx_nxt   = 5'd0;
               w_outrdy_nxt     = 1'b0;
               w_state_nxt      = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (!r_free_found && w_free_here) begin
               w_free_found_nxt = 1'b1;
               w_free_idx_nxt   = r_idx;
            end
            if (!w_last) begin
               w_idx_nxt = r_idx + 5'd1;
            end

            if (w_match) begin
               // Keys are unique, so the first match is the only match.
               w_state_nxt = ST_RESP;
               case (r_cmd)
                  c_CMD_LOOKUP: begin
                     w_dataout_nxt  = r_data[r_idx];
                     w_outvalid_nxt = 1'b1;
                  end
                  c_CMD_WRITE: begin
                     w_tbl_we  = 1'b1;
                     w_tbl_idx = r_idx;
                  end
                  c_CMD_DELETE: begin
                     w_clr_valid = 1'b1;
                     w_tbl_idx   = r_idx;
                  end
                  default: ;
               endcase
            end else if (w_last) begin
               w_state_nxt = ST_RESP;
               case (r_cmd)
                  c_CMD_WRITE: begin
                     if (w_free_any) begin
                        w_tbl_we    = 1'b1;
                        w_set_valid = 1'b1;
                        w_tbl_idx   = w_free_sel;
                     end else begin
                        w_pagefault_nxt = 1'b1;
                     end
                  end
                  c_CMD_LOOKUP,
                  c_CMD_DELETE: begin
                     w_pagefault_nxt = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         ST_RESP: begin
            w_outvalid_nxt  = 1'b0;
            w_pagefault_nxt = 1'b0;
            w_outrdy_nxt    = 1'b1;
            w_state_nxt     = ST_IDLE;
         end

         default: begin
            w_state_nxt  = ST_IDLE;
            w_outrdy_nxt = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Control / output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cmd        <= c_CMD_IDLE;
         r_key        <= 8'h00;
         r_din        <= 8'h00;
         r_idx        <= 5'd0;
         r_free_found <= 1'b0;
         r_free_idx   <= 5'd0;
         r_dataout    <= 8'h00;
         r_outvalid   <= 1'b0;
         r_pagefault  <= 1'b0;
         r_outrdy     <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_cmd        <= w_cmd_nxt;
         r_key        <= w_key_nxt;
         r_din        <= w_din_nxt;
         r_idx        <= w_idx_nxt;
         r_free_found <= w_free_found_nxt;
         r_free_idx   <= w_free_idx_nxt;
         r_dataout    <= w_dataout_nxt;
         r_outvalid   <= w_outvalid_nxt;
         r_pagefault  <= w_pagefault_nxt;
         r_outrdy     <= w_outrdy_nxt;
      end
   end

   // Valid bits are the only table state that reset must clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
      end else if (w_set_valid) begin
         r_valid[w_tbl_idx] <= 1'b1;
      end else if (w_clr_valid) begin
         r_valid[w_tbl_idx] <= 1'b0;
      end
   end

   // Key/data storage is qualified by the valid bits, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_tbl_we) begin
         r_keys[w_tbl_idx] <= r_key;
         r_data[w_tbl_idx] <= r_din;
      end
   end

endmodule
`default_nettype wire
